// File: rtl/nete_pkg.sv
// nete_pkg: shared definitions for the NETE transmit path.
//   nete_state_e : transmit mux FSM state
//   DEF_IN_W     : default wide input word width (bits)
//   DEF_OUT_W    : default AXIS output width (bits)
//   TDEST_W      : width of the AXIS tdest / channel index
package nete_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } nete_state_e;

    localparam int DEF_IN_W  = 256;
    localparam int DEF_OUT_W = 64;
    localparam int TDEST_W   = 4;

endpackage

// File: rtl/nete_tx_mux_if.sv
// nete_tx_mux_if: AXI-Stream transmit bus leaving the channel mux.
//   tx_tready : sink ready
//   tx_tdata  : beat data (OUT_W bits)
//   tx_tkeep  : byte enables (OUT_W/8 bits)
//   tx_tvalid : beat valid
//   tx_tlast  : final beat of packet
//   tx_tdest  : source channel index
// modport master = mux side, modport slave = sink side.
interface nete_tx_mux_if #(
    parameter int OUT_W = nete_pkg::DEF_OUT_W
);
    logic                        tx_tready;
    logic [OUT_W-1:0]            tx_tdata;
    logic [OUT_W/8-1:0]          tx_tkeep;
    logic                        tx_tvalid;
    logic                        tx_tlast;
    logic [nete_pkg::TDEST_W-1:0] tx_tdest;

    modport master (
        input  tx_tready,
        output tx_tdata, tx_tkeep, tx_tvalid, tx_tlast, tx_tdest
    );

    modport slave (
        output tx_tready,
        input  tx_tdata, tx_tkeep, tx_tvalid, tx_tlast, tx_tdest
    );
endinterface

// File: rtl/nete_rr_arb.sv
// nete_rr_arb: combinational round-robin arbiter.
//   i_req     : request vector (one bit per channel)
//   i_last    : index of the previously granted channel
//   o_gnt_oh  : one-hot grant
//   o_gnt_idx : grant index
//   o_any     : at least one request present
// Search starts at (i_last+1) mod NCH and proceeds upward with wrap.
module nete_rr_arb
    import nete_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]     i_req,
    input  logic [TDEST_W-1:0] i_last,
    output logic [NCH-1:0]     o_gnt_oh,
    output logic [TDEST_W-1:0] o_gnt_idx,
    output logic               o_any
);
    int unsigned w_idx;

    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_idx     = 0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            w_idx = (32'(i_last) + i) % NCH;
            if (!o_any && i_req[w_idx]) begin
                o_any           = 1'b1;
                o_gnt_oh[w_idx] = 1'b1;
                o_gnt_idx       = w_idx[TDEST_W-1:0];
            end
        end
    end
endmodule

// File: rtl/nete_tx_mux.sv
// nete_tx_mux: round-robin packet mux from NCH wide-word channels onto one
// narrower AXI-Stream output. Each accepted IN_W word is held and emitted
// lane 0 first as RATIO = IN_W/OUT_W beats (last word: only the lanes its
// keep covers, at least one). A grant is held until the tlast beat.
//   clk, rst_ : clock, asynchronous active-low reset
//   in_data   : NCH x IN_W words, channel c at [c*IN_W +: IN_W]
//   in_keep   : NCH x IN_W/8 byte enables (LSB-contiguous)
//   in_valid, in_last, in_rdy : per-channel word handshake
//   tx        : AXIS output (nete_tx_mux_if.master)
//   pkt_cnt   : NCH x 32 sent-packet counters (only with NETE_TX_MUX_STATS_EN)
// Optional feature macro: NETE_TX_MUX_STATS_EN
module nete_tx_mux
    import nete_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [NCH*IN_W-1:0]   in_data,
    input  logic [NCH*IN_W/8-1:0] in_keep,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH-1:0]        in_last,
    output logic [NCH-1:0]        in_rdy,
`ifdef NETE_TX_MUX_STATS_EN
    output logic [NCH*32-1:0]     pkt_cnt,
`endif
    nete_tx_mux_if.master         tx
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int OB    = OUT_W / 8;
    localparam int IB    = IN_W / 8;
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PW    = $clog2(IB + 1);

    nete_state_e        r_state, w_next_state;
    logic [NCH-1:0]     r_grant_oh;
    logic [TDEST_W-1:0] r_grant, r_last_grant;
    logic [IN_W-1:0]    r_hold;
    logic [IB-1:0]      r_hold_keep;
    logic               r_hold_last;
    logic [LW-1:0]      r_lane, r_lane_max;

    logic [IN_W-1:0]    w_word;
    logic [IB-1:0]      w_keep;
    logic [PW-1:0]      w_pop;
    logic [LW-1:0]      w_lane_max;
    logic               w_valid_g, w_last_g;
    logic [NCH-1:0]     w_arb_oh;
    logic [TDEST_W-1:0] w_arb_idx, w_arb_last;
    logic               w_arb_any, w_arb_load;
    logic               w_beat, w_final, w_done, w_take;

    // At the tlast handshake the outgoing grant becomes the new last_grant,
    // so the arbiter sees it one edge early to re-arbitrate without IDLE.
    assign w_arb_last = (r_state == ST_SEND) ? r_grant : r_last_grant;

    nete_rr_arb #(.NCH(NCH)) u_arb (
        .i_req     (in_valid),
        .i_last    (w_arb_last),
        .o_gnt_oh  (w_arb_oh),
        .o_gnt_idx (w_arb_idx),
        .o_any     (w_arb_any)
    );

    assign w_valid_g  = |(in_valid & r_grant_oh);
    assign w_last_g   = |(in_last & r_grant_oh);
    assign w_final    = (r_lane == r_lane_max);
    assign w_beat     = (r_state == ST_SEND) && tx.tx_tready;
    assign w_done     = w_beat && w_final && r_hold_last;
    assign w_take     = |(in_valid & in_rdy);
    assign w_arb_load = w_arb_any && ((r_state == ST_IDLE) || w_done);

    // Granted channel's word and keep, plus the final lane index to emit.
    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (r_grant_oh[c]) begin
                w_word = in_data[c*IN_W +: IN_W];
                w_keep = in_keep[c*IB +: IB];
            end
        end
        w_pop = '0;
        for (int unsigned b = 0; b < IB; b++) begin
            w_pop = w_pop + PW'(w_keep[b]);
        end
        w_lane_max = LW'(RATIO - 1);
        if (w_last_g) begin
            if (int'(w_pop) > OB) w_lane_max = LW'((int'(w_pop) + OB - 1) / OB - 1);
            else                  w_lane_max = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_arb_any) w_next_state = ST_LOAD;
            ST_LOAD: if (w_valid_g) w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_beat && w_final) begin
                    if (r_hold_last)     w_next_state = w_arb_any ? ST_LOAD : ST_IDLE;
                    else if (!w_valid_g) w_next_state = ST_LOAD;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_rdy       = '0;
        tx.tx_tvalid = 1'b0;
        tx.tx_tdata  = '0;
        tx.tx_tkeep  = '0;
        tx.tx_tlast  = 1'b0;
        tx.tx_tdest  = r_grant;
        case (r_state)
            ST_LOAD: in_rdy = r_grant_oh;
            ST_SEND: begin
                tx.tx_tvalid = 1'b1;
                for (int unsigned l = 0; l < RATIO; l++) begin
                    if (r_lane == LW'(l)) begin
                        tx.tx_tdata = r_hold[l*OUT_W +: OUT_W];
                        tx.tx_tkeep = r_hold_last ? r_hold_keep[l*OB +: OB] : '1;
                    end
                end
                tx.tx_tlast = r_hold_last && w_final;
                // Accept the next word alongside the final beat for zero-bubble flow.
                if (!r_hold_last && w_final && tx.tx_tready) in_rdy = r_grant_oh;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_grant_oh   <= '0;
            r_grant      <= '0;
            r_last_grant <= TDEST_W'(NCH - 1);
            r_hold       <= '0;
            r_hold_keep  <= '0;
            r_hold_last  <= 1'b0;
            r_lane       <= '0;
            r_lane_max   <= '0;
        end else begin
            if (w_take) begin
                r_hold      <= w_word;
                r_hold_keep <= w_keep;
                r_hold_last <= w_last_g;
                r_lane      <= '0;
                r_lane_max  <= w_lane_max;
            end else if (w_beat && !w_final) begin
                r_lane <= r_lane + LW'(1);
            end
            if (w_arb_load) begin
                r_grant    <= w_arb_idx;
                r_grant_oh <= w_arb_oh;
            end
            if (w_done) r_last_grant <= r_grant;
        end
    end

`ifdef NETE_TX_MUX_STATS_EN
    logic [31:0] r_pkt_cnt [NCH];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int unsigned c = 0; c < NCH; c++) r_pkt_cnt[c] <= '0;
        end else if (w_done) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (r_grant_oh[c]) r_pkt_cnt[c] <= r_pkt_cnt[c] + 32'd1;
            end
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int unsigned c = 0; c < NCH; c++) pkt_cnt[c*32 +: 32] = r_pkt_cnt[c];
    end
`endif
endmodule

// File: tb/tb_nete_tx_mux.sv
// tb_nete_tx_mux: scoreboard bench for nete_tx_mux (NCH=2, 256->64).
// Packets are expanded into expected beats per channel when issued; a
// negedge monitor pops and compares each output handshake.
module tb_nete_tx_mux;
    localparam int NCH   = 2;
    localparam int IN_W  = 256;
    localparam int OUT_W = 64;
    localparam int IB    = IN_W / 8;
    localparam int OB    = OUT_W / 8;
    localparam int RATIO = IN_W / OUT_W;

    typedef struct { logic [IN_W-1:0] data; logic [IB-1:0] keep; logic last; } word_t;
    typedef struct { logic [OUT_W-1:0] data; logic [OB-1:0] keep; logic last; } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_ = 1'b0;
    logic [NCH*IN_W-1:0]   in_data = '0;
    logic [NCH*IN_W/8-1:0] in_keep = '0;
    logic [NCH-1:0]        in_valid = '0;
    logic [NCH-1:0]        in_last = '0;
    logic [NCH-1:0]        in_rdy;
`ifdef NETE_TX_MUX_STATS_EN
    logic [NCH*32-1:0]     pkt_cnt;
`endif

    nete_tx_mux_if #(.OUT_W(OUT_W)) tx_if ();

    nete_tx_mux #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .in_data  (in_data),
        .in_keep  (in_keep),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_rdy   (in_rdy),
`ifdef NETE_TX_MUX_STATS_EN
        .pkt_cnt  (pkt_cnt),
`endif
        .tx       (tx_if)
    );

    always #5 clk = ~clk;

    word_t       drv_q [NCH][$];
    beat_t       exp_q [NCH][$];
    int          order_q [$];
    int unsigned tests = 0, fails = 0, beats_seen = 0;
    bit          hs [NCH];
    bit          in_pkt = 1'b0, prev_stall = 1'b0, gaps_en = 1'b0;
    int          cur_dest = 0, tready_mode = 0;
    logic [77:0] prev_vec = '0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IB-1:0] keep_n(input int n);
        logic [IB-1:0] k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    // Reference model: a word becomes RATIO full beats, or for the last word
    // max(1, ceil(bytes/OB)) beats with the matching keep slices.
    task automatic add_pkt(input int c, input int nwords, input int nlast);
        for (int w = 0; w < nwords; w++) begin
            word_t wd;
            int    nb;
            for (int i = 0; i < IN_W / 32; i++) wd.data[i*32 +: 32] = $urandom;
            wd.last = (w == nwords - 1);
            wd.keep = wd.last ? keep_n(nlast) : '1;
            drv_q[c].push_back(wd);
            nb = !wd.last ? RATIO : (($countones(wd.keep) == 0) ? 1 : ($countones(wd.keep) + OB - 1) / OB);
            for (int b = 0; b < nb; b++) begin
                beat_t e;
                e.data = wd.data[b*OUT_W +: OUT_W];
                e.keep = wd.last ? wd.keep[b*OB +: OB] : '1;
                e.last = wd.last && (b == nb - 1);
                exp_q[c].push_back(e);
            end
        end
    endtask

    function automatic int pending();
        int n = order_q.size();
        for (int c = 0; c < NCH; c++) n += exp_q[c].size() + drv_q[c].size();
        return n;
    endfunction

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (pending() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 128'(pending()), 128'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic flush();
        for (int c = 0; c < NCH; c++) begin
            drv_q[c].delete();
            exp_q[c].delete();
        end
        order_q.delete();
        in_valid   = '0;
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
    endtask

    // Input driver and tready generator: change only #1 after posedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       tx_if.tx_tready = 1'b1;
                1:       tx_if.tx_tready = !tx_if.tx_tready;
                default: tx_if.tx_tready = ($urandom_range(0, 3) != 0);
            endcase
            for (int c = 0; c < NCH; c++) begin
                if (hs[c]) begin
                    if (drv_q[c].size() > 0) drv_q[c].delete(0);
                    in_valid[c] = 1'b0;
                    hs[c] = 1'b0;
                end
                if (!in_valid[c] && drv_q[c].size() > 0 && (!gaps_en || $urandom_range(0, 2) != 0)) begin
                    in_data[c*IN_W +: IN_W] = drv_q[c][0].data;
                    in_keep[c*IB +: IB]     = drv_q[c][0].keep;
                    in_last[c]              = drv_q[c][0].last;
                    in_valid[c]             = 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_) begin
            for (int c = 0; c < NCH; c++) hs[c] = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) hs[c] = in_valid[c] && in_rdy[c];
            check("rdy_onehot0", 128'($countones(in_rdy) <= 1), 128'd1);
            if (prev_stall)
                check("stall_hold", 128'({tx_if.tx_tdata, tx_if.tx_tkeep, tx_if.tx_tlast,
                                          tx_if.tx_tdest, tx_if.tx_tvalid}), 128'(prev_vec));
            if (tx_if.tx_tvalid && tx_if.tx_tready) begin
                int    d;
                beat_t e;
                d = int'(tx_if.tx_tdest);
                if (in_pkt) check("no_interleave", 128'(d), 128'(cur_dest));
                else if (order_q.size() > 0) check("arb_order", 128'(d), 128'(order_q.pop_front()));
                if (d >= NCH || exp_q[d].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got tdest %0d with no expected beat", d);
                end else begin
                    e = exp_q[d].pop_front();
                    check("beat", 128'({tx_if.tx_tdata, tx_if.tx_tkeep, tx_if.tx_tlast}),
                          128'({e.data, e.keep, e.last}));
                end
                in_pkt   = !tx_if.tx_tlast;
                cur_dest = d;
                beats_seen++;
            end
            prev_stall = tx_if.tx_tvalid && !tx_if.tx_tready;
            prev_vec   = {tx_if.tx_tdata, tx_if.tx_tkeep, tx_if.tx_tlast, tx_if.tx_tdest, tx_if.tx_tvalid};
        end
    end

    initial begin
        int unsigned base, n;
        tx_if.tx_tready = 1'b1;

        // Both channels valid from reset, single-word packets: strict alternation.
        add_pkt(0, 1, IB);
        add_pkt(1, 1, 5);
        add_pkt(0, 1, 17);
        add_pkt(1, 1, 0);
        order_q = '{0, 1, 0, 1};
        repeat (3) @(posedge clk);
        #2;
        check("reset_out", 128'({tx_if.tx_tvalid, tx_if.tx_tlast, tx_if.tx_tdata, tx_if.tx_tkeep,
                                 tx_if.tx_tdest, in_rdy}), 128'd0);
        rst_ = 1'b1;
        drain(200);

        // Two-word packet, last keep 0xFF: 4 + 1 beats.
        base = beats_seen;
        add_pkt(0, 2, 8);
        drain(200);
        check("two_word_beats", 128'(beats_seen - base), 128'd5);

        // Short last words: keep 0x0F and keep 0 each give one beat.
        base = beats_seen;
        add_pkt(0, 1, 4);
        add_pkt(0, 1, 0);
        drain(200);
        check("short_last_beats", 128'(beats_seen - base), 128'd2);

        // tready toggling over a 3-word full packet.
        tready_mode = 1;
        base = beats_seen;
        add_pkt(0, 3, IB);
        drain(400);
        check("toggle_beats", 128'(beats_seen - base), 128'd12);

        // Randomized traffic with input gaps and random backpressure.
        tready_mode = 2;
        gaps_en = 1'b1;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < NCH; c++) add_pkt(c, $urandom_range(1, 3), $urandom_range(0, IB));
        end
        drain(5000);

        // Reset during the third beat of a packet.
        tready_mode = 0;
        gaps_en = 1'b0;
        repeat (2) @(posedge clk);
        base = beats_seen;
        add_pkt(0, 2, IB);
        n = 0;
        while (beats_seen < base + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("reach_beat3", 128'(beats_seen - base), 128'd2);
        #2;
        rst_ = 1'b0;
        #1;
        check("reset_mid_out", 128'({tx_if.tx_tvalid, tx_if.tx_tlast, tx_if.tx_tdata, tx_if.tx_tkeep,
                                     tx_if.tx_tdest, in_rdy}), 128'd0);
        flush();
        repeat (2) @(posedge clk);
        #2;
        rst_ = 1'b1;
        add_pkt(0, 1, 9);
        for (int i = 0; i < 3; i++) add_pkt(1, 1, $urandom_range(0, IB));
        order_q = '{0, 1, 1, 1};
        drain(300);
`ifdef NETE_TX_MUX_STATS_EN
        check("pkt_cnt_ch0", 128'(pkt_cnt[31:0]), 128'd1);
        check("pkt_cnt_ch1", 128'(pkt_cnt[63:32]), 128'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nete_tx_mux.md
NETE_TX_MUX -- requirements
Module: nete_tx_mux

Interface
REQ-001 SHALL have parameter NCH, default 2, number of input packet channels (1..16).
REQ-002 SHALL have parameter IN_W, default 256, input word width in bits (multiple of OUT_W).
REQ-003 SHALL have parameter OUT_W, default 64, AXIS output width in bits; RATIO = IN_W/OUT_W, OB = OUT_W/8.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_  in  1  async active-low reset.
REQ-005 in_data  in  NCH*IN_W  per-channel wide word, channel c at bits [c*IN_W +: IN_W].
REQ-006 in_keep  in  NCH*IN_W/8  per-channel byte enables, LSB-contiguous.
REQ-007 in_valid / in_last  in  NCH  per-channel word valid / last word of packet.
REQ-008 in_rdy  out  NCH  per-channel word accept; transfer when in_valid&in_rdy.
REQ-009 tx_tready  in  1; tx_tdata  out  OUT_W; tx_tkeep  out  OB; tx_tvalid  out  1; tx_tlast  out  1; tx_tdest  out  4 (granted channel index).
REQ-010 pkt_cnt  out  NCH*32  per-channel sent-packet counters (present only with NETE_TX_MUX_STATS_EN).

Function
REQ-011 FSM states IDLE, LOAD, SEND; reset state IDLE.
REQ-012 IDLE: when any in_valid high, grant the first valid channel searching from (last_grant+1) mod NCH upward; go to LOAD next cycle.
REQ-013 Grant held from first word until the tlast beat handshakes; no interleaving of packets on output.
REQ-014 LOAD: in_rdy[grant]=1; accepted word captured into holding register next edge; go to SEND.
REQ-015 SEND: emit lane 0 (bits OUT_W-1:0) first, then ascending lanes, one beat per tx_tvalid&tx_tready.
REQ-016 Non-last word: exactly RATIO beats, tx_tkeep all-ones, tx_tlast=0.
REQ-017 Last word: beats = max(1, ceil(popcount(keep)/OB)); tx_tkeep = that lane's keep slice; tx_tlast=1 on final beat only.
REQ-018 Latency: word accepted on edge N -> first beat tx_tvalid high after edge N (same cycle register visible).
REQ-019 in_rdy[grant] SHALL also assert during the final beat of a non-last word so tx_tready held high yields zero-bubble throughput.
REQ-020 After tlast handshake: last_grant=grant; if any in_valid, re-arbitrate directly (skip IDLE, one cycle ARB in LOAD); else IDLE.
REQ-021 tx_tdata/tkeep/tlast/tdest SHALL stay stable while tx_tvalid=1 and tx_tready=0.
REQ-022 in_rdy SHALL be 0 for all non-granted channels at all times.
REQ-023 Granted channel dropping in_valid mid-packet: FSM waits in LOAD, tx_tvalid=0; no timeout.

Reset
REQ-024 On rst_ low, asynchronously: state=IDLE, tx_tvalid=0, tx_tlast=0, tx_tdata=0, tx_tkeep=0, tx_tdest=0, in_rdy=0, last_grant=NCH-1, pkt_cnt=0.
REQ-025 Reset mid-packet discards the in-flight packet; after release first grant goes to channel 0 if valid.

Configuration
REQ-026 With NETE_TX_MUX_STATS_EN defined: pkt_cnt[c] increments by 1 on each tlast handshake of channel c, wraps 0xFFFFFFFF->0.
REQ-027 Without NETE_TX_MUX_STATS_EN: pkt_cnt port and counters absent; all other behaviour identical.

Structure
REQ-028 Shared package nete_pkg SHALL hold the FSM state typedef, default widths (256/64) and the 4-bit TDEST width constant.
REQ-029 Round-robin arbiter SHALL be a separate sub-module nete_rr_arb (request vector, last grant in; one-hot + index out).
REQ-030 Holding register, lane counter and FSM reside in nete_tx_mux; no internal FIFO.

Verification
REQ-031 NCH=2, ch0 2-word packet, keep last=0x0000_00FF, tready=1 -> 5 beats, tdest=0, tlast on beat 5, tkeep beat 5=0xFF.
REQ-032 Both channels valid from reset, 1-word packets each -> order ch0, ch1, ch0, ch1; tdest alternates.
REQ-033 Last word keep=0x0000_000F -> single beat, tkeep=0x0F, tlast=1; keep=0 -> single beat, tkeep=0x00, tlast=1.
REQ-034 tready toggled 1-0 every cycle over 3-word packet -> 12 beats, data unchanged while stalled, no beat lost/duplicated.
REQ-035 rst_ asserted during beat 3 of a packet -> all outputs 0 same cycle; after release next packet starts clean on ch0.
REQ-036 STATS_EN: 3 packets ch1, 1 packet ch0 -> pkt_cnt ch0=1, ch1=3; preload-free wrap checked by forcing 0xFFFFFFFF -> 0.
